fxu_pipe: RTL and testbench

//  Parametrised, pipelined fixed-point unit: executes MOV/ADD/SUB/JEQ/JLT ops from reservation stations.

---
 rtl/fxu_pipe_pkg.sv | 8 +
 rtl/fxu_alu.sv | 18 +
 rtl/fxu_pipe.sv | 52 +++++
 tb/tb_fxu_pipe.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fxu_pipe_pkg.sv
// fxu_pipe_pkg: opcode encodings shared by the fixed-point unit, RS and decoder
package fxu_pipe_pkg;
  localparam logic [3:0] OP_MOV = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_JEQ = 4'd6;
  localparam logic [3:0] OP_JLT = 4'd7;
endpackage

// File: rtl/fxu_alu.sv
// fxu_alu: combinational fixed-point op evaluation; unknown opcodes give 0
module fxu_alu
  import fxu_pipe_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] val0,
  input  logic [WIDTH-1:0] val1,
  output logic [WIDTH-1:0] res
);
  always_comb
    res = op == OP_MOV ? val0 :
          op == OP_ADD ? val0 + val1 :
          op == OP_SUB ? val0 - val1 :
          op == OP_JEQ ? WIDTH'(val0 == val1) :
          op == OP_JLT ? WIDTH'($signed(val0) < $signed(val1)) : '0;
endmodule

// File: rtl/fxu_pipe.sv
// fxu_pipe: STAGES-deep fixed-point pipe with lockstep stall toward the CDB and flush
module fxu_pipe
  import fxu_pipe_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int TAG_W  = 6,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [TAG_W-1:0] rs_num,
  input  logic [3:0]       op,
  input  logic [15:0]      pc,
  input  logic [WIDTH-1:0] val0,
  input  logic [WIDTH-1:0] val1,
  output logic             busy,
  input  logic             flush,
  output logic             valid_out,
  input  logic             out_ready,
  output logic [TAG_W-1:0] rs_num_out,
  output logic [3:0]       op_out,
  output logic [15:0]      pc_out,
  output logic [WIDTH-1:0] res_out
);
  typedef struct packed {
    logic             v;
    logic [TAG_W-1:0] tag;
    logic [3:0]       op;
    logic [15:0]      pc;
    logic [WIDTH-1:0] res;
  } stage_t;
  stage_t [STAGES-1:0] s, nxt;
  logic [WIDTH-1:0] res;
  logic adv;
  fxu_alu #(.WIDTH(WIDTH)) alu (.op(op), .val0(val0), .val1(val1), .res(res));
  assign adv = !s[STAGES-1].v || out_ready;
  assign busy = !adv;
  // Bubbles enter as all-zero records so idle payload outputs read 0
  always_comb begin
    nxt = s << $bits(stage_t);
    nxt[0] = valid ? stage_t'{v: 1'b1, tag: rs_num, op: op, pc: pc, res: res} : stage_t'('0);
  end
  always_ff @(posedge clk)
    if (reset || flush) s <= '0;
    else if (adv) s <= nxt;
  assign valid_out  = s[STAGES-1].v;
  assign rs_num_out = s[STAGES-1].tag;
  assign op_out     = s[STAGES-1].op;
  assign pc_out     = s[STAGES-1].pc;
  assign res_out    = s[STAGES-1].res;
endmodule

// File: tb/tb_fxu_pipe.sv
// tb_fxu_pipe: three fxu_pipe configurations driven in lockstep, checked by per-instance scoreboards
module tb_fxu_pipe;
  typedef struct packed {
    logic [5:0]  tag;
    logic [3:0]  op;
    logic [15:0] pc;
    logic [31:0] res;
  } exp_t;
  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [15:0] x16;
    logic [31:0] x32;
  } vec_t;
  logic clk = 0;
  logic reset, flush, out_ready;
  logic [5:0] rs_num;
  logic [3:0] op;
  logic [15:0] pc;
  logic [31:0] val0, val1;
  logic [2:0] v_in, busy, vo, acc;
  logic [2:0][5:0] tag_o;
  logic [2:0][3:0] op_o;
  logic [2:0][15:0] pc_o;
  logic [15:0] r16;
  logic [31:0] ra, rb;
  logic [5:0] etag;
  logic [3:0] eop;
  logic [15:0] epc, e16;
  logic [31:0] e32;
  exp_t q0[$], q1[$], q2[$];
  int total = 0, bad = 0, steps = 0;
  always #5 clk = ~clk;
  fxu_pipe #(.WIDTH(16), .TAG_W(6), .STAGES(2)) d0 (
    .clk(clk), .reset(reset), .valid(v_in[0]), .rs_num(rs_num), .op(op), .pc(pc),
    .val0(val0[15:0]), .val1(val1[15:0]), .busy(busy[0]), .flush(flush), .valid_out(vo[0]),
    .out_ready(out_ready), .rs_num_out(tag_o[0]), .op_out(op_o[0]), .pc_out(pc_o[0]), .res_out(r16));
  fxu_pipe #(.WIDTH(32), .TAG_W(6), .STAGES(1)) d1 (
    .clk(clk), .reset(reset), .valid(v_in[1]), .rs_num(rs_num), .op(op), .pc(pc),
    .val0(val0), .val1(val1), .busy(busy[1]), .flush(flush), .valid_out(vo[1]),
    .out_ready(out_ready), .rs_num_out(tag_o[1]), .op_out(op_o[1]), .pc_out(pc_o[1]), .res_out(ra));
  fxu_pipe #(.WIDTH(32), .TAG_W(6), .STAGES(4)) d2 (
    .clk(clk), .reset(reset), .valid(v_in[2]), .rs_num(rs_num), .op(op), .pc(pc),
    .val0(val0), .val1(val1), .busy(busy[2]), .flush(flush), .valid_out(vo[2]),
    .out_ready(out_ready), .rs_num_out(tag_o[2]), .op_out(op_o[2]), .pc_out(pc_o[2]), .res_out(rb));

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", n, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] res_of(int k);
    return k == 0 ? {16'h0, r16} : k == 1 ? ra : rb;
  endfunction
  task automatic push(int k, exp_t e);
    if (k == 0) q0.push_back(e);
    else if (k == 1) q1.push_back(e);
    else q2.push_back(e);
  endtask
  task automatic pop(int k, output exp_t e, output bit ok);
    ok = 0;
    e = '0;
    if (k == 0 && q0.size() > 0) begin e = q0.pop_front(); ok = 1; end
    if (k == 1 && q1.size() > 0) begin e = q1.pop_front(); ok = 1; end
    if (k == 2 && q2.size() > 0) begin e = q2.pop_front(); ok = 1; end
  endtask

  // consume-side scoreboard: a result leaves when valid_out && out_ready at the coming edge
  always @(negedge clk) begin
    exp_t e;
    bit ok;
    for (int k = 0; k < 3; k++) begin
      if (!reset && vo[k] && out_ready) begin
        pop(k, e, ok);
        chk($sformatf("unexpected_out%0d", k), 32'(ok), 1);
        if (ok) begin
          chk($sformatf("tag%0d", k), 32'(tag_o[k]), 32'(e.tag));
          chk($sformatf("op%0d", k), 32'(op_o[k]), 32'(e.op));
          chk($sformatf("pc%0d", k), 32'(pc_o[k]), 32'(e.pc));
          chk($sformatf("res%0d", k), res_of(k), e.res);
        end
      end else if (!reset && !vo[k])
        chk($sformatf("idle_payload%0d", k), 32'(|{tag_o[k], op_o[k], pc_o[k], res_of(k)}), 0);
    end
    if (flush || reset) begin
      q0.delete();
      q1.delete();
      q2.delete();
    end
  end

  task automatic step();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      acc[k] = v_in[k] && !busy[k] && !flush && !reset;
      if (acc[k]) push(k, exp_t'{etag, eop, epc, k == 0 ? {16'h0, e16} : e32});
    end
    @(posedge clk);
    #1;
    v_in = v_in & ~acc;
    steps++;
  endtask
  task automatic present(logic [3:0] o, logic [31:0] a, logic [31:0] b, logic [5:0] t,
                         logic [15:0] p, logic [15:0] x16, logic [31:0] x32);
    op = o; val0 = a; val1 = b; rs_num = t; pc = p;
    eop = o; etag = t; epc = p; e16 = x16; e32 = x32;
    v_in = '1;
  endtask
  task automatic issue(logic [3:0] o, logic [31:0] a, logic [31:0] b, logic [5:0] t,
                       logic [15:0] p, logic [15:0] x16, logic [31:0] x32);
    present(o, a, b, t, p, x16, x32);
    for (int n = 0; n < 40 && v_in != 0; n++) step();
    chk("accept_timeout", 32'(v_in), 0);
  endtask
  task automatic drain();
    for (int n = 0; n < 40 && (q0.size() + q1.size() + q2.size()) != 0; n++) step();
    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);
    chk("drain_q2", q2.size(), 0);
  endtask
  task automatic all_zero(string n);
    chk({n, "_vo"}, 32'(vo), 0);
    chk({n, "_busy"}, 32'(busy), 0);
    chk({n, "_tag"}, 32'(|tag_o), 0);
    chk({n, "_op"}, 32'(|op_o), 0);
    chk({n, "_pc"}, 32'(|pc_o), 0);
    chk({n, "_res"}, 32'(|{r16, ra, rb}), 0);
  endtask

  initial begin
    vec_t tbl[14];
    logic [2:0] lat[5];
    int s0;
    tbl = '{
      '{4'h1, 32'h3, 32'h4, 16'h0007, 32'h7},
      '{4'h0, 32'h1234ABCD, 32'h0, 16'hABCD, 32'h1234ABCD},
      '{4'h2, 32'h0, 32'h1, 16'hFFFF, 32'hFFFFFFFF},
      '{4'h6, 32'h9, 32'h9, 16'h0001, 32'h1},
      '{4'h6, 32'h9, 32'h8, 16'h0000, 32'h0},
      '{4'h7, 32'hFFFF, 32'h1, 16'h0001, 32'h0},
      '{4'h7, 32'hFFFFFFFF, 32'h1, 16'h0001, 32'h1},
      '{4'h1, 32'hFFFFFFFF, 32'h1, 16'h0000, 32'h0},
      '{4'hF, 32'h5, 32'h6, 16'h0000, 32'h0},
      '{4'h3, 32'h5, 32'h6, 16'h0000, 32'h0},
      '{4'h2, 32'h5, 32'h7, 16'hFFFE, 32'hFFFFFFFE},
      '{4'h7, 32'h1, 32'hFFFF, 16'h0000, 32'h1},
      '{4'h7, 32'h8000, 32'h7FFF, 16'h0001, 32'h0},
      '{4'h1, 32'h18000, 32'h18000, 16'h0000, 32'h30000}
    };
    lat = '{3'b010, 3'b001, 3'b000, 3'b100, 3'b000};
    reset = 1; flush = 0; out_ready = 0; v_in = 0;
    op = 0; val0 = 0; val1 = 0; rs_num = 0; pc = 0; acc = 0;
    etag = 0; eop = 0; epc = 0; e16 = 0; e32 = 0;
    step();
    step();
    all_zero("reset");
    reset = 0;
    out_ready = 1;
    // isolated ADD: valid_out rises STAGES-1 edges after the accepting edge
    issue(4'h1, 32'h3, 32'h4, 6'd5, 16'h0040, 16'h0007, 32'h7);
    for (int j = 0; j < 5; j++) begin
      chk($sformatf("latency_j%0d", j), 32'(vo), 32'(lat[j]));
      if (j == 1) begin
        chk("lat_tag", 32'(tag_o[0]), 5);
        chk("lat_res", 32'(r16), 7);
      end
      step();
    end
    drain();
    s0 = steps;
    for (int i = 0; i < 14; i++)
      issue(tbl[i].op, tbl[i].a, tbl[i].b, 6'(i + 1), 16'(16'h100 + i), tbl[i].x16, tbl[i].x32);
    chk("throughput", steps - s0, 14);
    drain();
    // stall: out_ready low while issuing, outputs must hold
    out_ready = 0;
    issue(4'h0, 32'h11, 32'h0, 6'd1, 16'h0200, 16'h0011, 32'h11);
    present(4'h0, 32'h22, 32'h0, 6'd2, 16'h0201, 16'h0022, 32'h22);
    step();
    chk("stall_vo", 32'(vo), 3'b011);
    chk("stall_vin", 32'(v_in), 3'b010);
    for (int c = 0; c < 3; c++) begin
      chk("stall_busy", 32'(busy[1:0]), 2'b11);
      chk("stall_r16", 32'(r16), 32'h11);
      chk("stall_ra", ra, 32'h11);
      chk("stall_tag0", 32'(tag_o[0]), 1);
      chk("stall_tag1", 32'(tag_o[1]), 1);
      step();
    end
    out_ready = 1;
    for (int n = 0; n < 40 && v_in != 0; n++) step();
    chk("stall_accept", 32'(v_in), 0);
    drain();
    // flush with two in flight and a same-cycle issue
    issue(4'h1, 32'h1, 32'h1, 6'd10, 16'h0300, 16'h0002, 32'h2);
    issue(4'h2, 32'h9, 32'h2, 6'd11, 16'h0301, 16'h0007, 32'h7);
    present(4'h0, 32'h77, 32'h0, 6'd12, 16'h0302, 16'h0077, 32'h77);
    flush = 1;
    step();
    flush = 0;
    v_in = 0;
    chk("flush_vo", 32'(vo), 0);
    chk("flush_busy", 32'(busy), 0);
    repeat (6) step();
    drain();
    // reset during a stall discards everything, valid during reset ignored
    out_ready = 0;
    issue(4'h0, 32'h55, 32'h0, 6'd20, 16'h0400, 16'h0055, 32'h55);
    present(4'h0, 32'h66, 32'h0, 6'd21, 16'h0401, 16'h0066, 32'h66);
    step();
    reset = 1;
    v_in = '1;
    step();
    all_zero("midreset");
    reset = 0;
    v_in = 0;
    out_ready = 1;
    repeat (6) step();
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
